// File: rtl/page_flip_scheduler.sv
// page_flip_scheduler
// Photo page flipping for the display read path. Touch and slideshow requests
// pick a target page, and the flip lands on a display frame boundary. It is held
// off while the photo loader is writing SDRAM. After each flip, requests are
// locked out for a few frames.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | accepting touch/auto requests, slideshow counter running
// PENDING | target latched, waiting for a frame pulse with loader idle
// HOLD    | flip done, requests locked out for HOLD_FRAMES frame pulses
module page_flip_scheduler #(
    parameter logic [20:0] BUFFER_SIZE = 21'h12C000,
    parameter int          NUM_PAGES   = 3,
    parameter int          START_PAGE  = 1,
    parameter int          HOLD_FRAMES = 2
) (
    input  logic        iCLK,
    input  logic        iRSTN,
    input  logic        iNEXT_REQ,
    input  logic        iPREV_REQ,
    input  logic        iVSYNC,
    input  logic        iAUTO_EN,
    input  logic [7:0]  iAUTO_PERIOD,
    input  logic        iLOAD_BUSY,
    output logic [22:0] oRD_ADDR,
    output logic [1:0]  oPAGE,
    output logic        oFACTOR_RSTN,
    output logic        oFLIP_DONE,
    output logic        oBUSY
);

    localparam int          HW         = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES);
    localparam logic [1:0]  LAST_PAGE  = 2'(NUM_PAGES - 1);
    localparam logic [1:0]  RST_PAGE   = 2'(START_PAGE);
    localparam logic [22:0] BUF23      = {2'b00, BUFFER_SIZE};
    localparam logic [22:0] RST_ADDR   = 23'(RST_PAGE) * BUF23;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [1:0]    page, page_n;
    logic [1:0]    target, target_n;
    logic [22:0]   addr, addr_n;
    logic [7:0]    slide_cnt, slide_cnt_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          flip_q, flip_n;

    logic          vs_s1, vs_s2, vs_d;
    logic          frame_pulse;
    logic          next_ok, prev_ok, auto_ok;

    // Two-flop synchroniser for iVSYNC plus one delay stage for edge detect.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            vs_s1 <= iVSYNC;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
        end
    end

    assign frame_pulse = vs_d & ~vs_s2;

    assign next_ok = iNEXT_REQ & ~iPREV_REQ & (page < LAST_PAGE);
    assign prev_ok = iPREV_REQ & ~iNEXT_REQ & (page != 2'd0);
    assign auto_ok = iAUTO_EN & (iAUTO_PERIOD != 8'd0);

    // State, page, address and counter registers.
    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state     <= IDLE;
            page      <= RST_PAGE;
            target    <= RST_PAGE;
            addr      <= RST_ADDR;
            slide_cnt <= 8'd0;
            hold_cnt  <= '0;
            flip_q    <= 1'b0;
        end else begin
            state     <= state_n;
            page      <= page_n;
            target    <= target_n;
            addr      <= addr_n;
            slide_cnt <= slide_cnt_n;
            hold_cnt  <= hold_cnt_n;
            flip_q    <= flip_n;
        end
    end

    // Next-state logic: request arbitration in IDLE, deferred flip in PENDING, lockout in HOLD.
    always_comb begin
        state_n     = state;
        page_n      = page;
        target_n    = target;
        addr_n      = addr;
        slide_cnt_n = slide_cnt;
        hold_cnt_n  = hold_cnt;
        flip_n      = 1'b0;
        case (state)
            IDLE: begin
                if (next_ok) begin
                    target_n    = 2'(page + 2'd1);
                    slide_cnt_n = 8'd0;
                    state_n     = PENDING;
                end else if (prev_ok) begin
                    target_n    = 2'(page - 2'd1);
                    slide_cnt_n = 8'd0;
                    state_n     = PENDING;
                end else if (!auto_ok) begin
                    slide_cnt_n = 8'd0;
                end else if (slide_cnt >= iAUTO_PERIOD) begin
                    // slideshow wraps from the last page back to page 0
                    target_n    = (page >= LAST_PAGE) ? 2'd0 : 2'(page + 2'd1);
                    slide_cnt_n = 8'd0;
                    state_n     = PENDING;
                end else if (frame_pulse) begin
                    slide_cnt_n = slide_cnt + 8'd1;
                end
            end
            PENDING: begin
                slide_cnt_n = 8'd0;
                if (frame_pulse && !iLOAD_BUSY) begin
                    page_n     = target;
                    addr_n     = 23'(target) * BUF23;
                    flip_n     = 1'b1;
                    hold_cnt_n = HOLD_LOAD;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                slide_cnt_n = 8'd0;
                if (hold_cnt == '0) begin
                    state_n = IDLE;
                end else if (frame_pulse) begin
                    hold_cnt_n = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign oPAGE        = page;
    assign oRD_ADDR     = addr;
    assign oFLIP_DONE   = flip_q;
    assign oFACTOR_RSTN = ~flip_q;
    assign oBUSY        = (state != IDLE);

endmodule

// File: tb/tb_page_flip_scheduler.sv
// Directed bench for page_flip_scheduler: touch flips, boundaries, slideshow,
// loader deferral, hold lockout and reset abort.
module tb_page_flip_scheduler;

    logic        iCLK;
    logic        iRSTN;
    logic        iNEXT_REQ;
    logic        iPREV_REQ;
    logic        iVSYNC;
    logic        iAUTO_EN;
    logic [7:0]  iAUTO_PERIOD;
    logic        iLOAD_BUSY;
    logic [22:0] oRD_ADDR;
    logic [1:0]  oPAGE;
    logic        oFACTOR_RSTN;
    logic        oFLIP_DONE;
    logic        oBUSY;

    int tests;
    int fails;
    int flip_count;
    int snap;

    page_flip_scheduler dut (
        .iCLK         (iCLK),
        .iRSTN        (iRSTN),
        .iNEXT_REQ    (iNEXT_REQ),
        .iPREV_REQ    (iPREV_REQ),
        .iVSYNC       (iVSYNC),
        .iAUTO_EN     (iAUTO_EN),
        .iAUTO_PERIOD (iAUTO_PERIOD),
        .iLOAD_BUSY   (iLOAD_BUSY),
        .oRD_ADDR     (oRD_ADDR),
        .oPAGE        (oPAGE),
        .oFACTOR_RSTN (oFACTOR_RSTN),
        .oFLIP_DONE   (oFLIP_DONE),
        .oBUSY        (oBUSY)
    );

    // 100 MHz system clock
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // count flip pulses, sampled away from the active edge
    always @(negedge iCLK) if (oFLIP_DONE === 1'b1) flip_count++;

    // one display frame: vsync low for 4 cycles, then high for 4 cycles
    task automatic frame();
        @(negedge iCLK);
        iVSYNC = 1'b0;
        repeat (4) @(negedge iCLK);
        iVSYNC = 1'b1;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic pulse_req(input logic nxt, input logic prv);
        @(negedge iCLK);
        iNEXT_REQ = nxt;
        iPREV_REQ = prv;
        @(negedge iCLK);
        iNEXT_REQ = 1'b0;
        iPREV_REQ = 1'b0;
    endtask

    task automatic test_reset();
        iRSTN = 1'b0; iNEXT_REQ = 1'b0; iPREV_REQ = 1'b0; iVSYNC = 1'b1;
        iAUTO_EN = 1'b0; iAUTO_PERIOD = 8'd0; iLOAD_BUSY = 1'b0;
        repeat (3) @(negedge iCLK);
        if (oPAGE !== 2'd1) begin fails++; $display("FAIL reset_page got %0d exp 1", oPAGE); end
        tests++;
        if (oRD_ADDR !== 23'h12C000) begin fails++; $display("FAIL reset_addr got %h exp 12c000", oRD_ADDR); end
        tests++;
        if (oBUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", oBUSY); end
        tests++;
        if (oFLIP_DONE !== 1'b0 || oFACTOR_RSTN !== 1'b1) begin
            fails++; $display("FAIL reset_flip got done=%b frst=%b exp 0/1", oFLIP_DONE, oFACTOR_RSTN);
        end
        tests++;
        iRSTN = 1'b1;
        repeat (6) @(negedge iCLK);
        if (oBUSY !== 1'b0 || flip_count != 0) begin
            fails++; $display("FAIL reset_release got busy=%b flips=%0d exp 0/0", oBUSY, flip_count);
        end
        tests++;
    endtask

    task automatic test_next();
        pulse_req(1'b1, 1'b0);
        if (oBUSY !== 1'b1 || oPAGE !== 2'd1) begin
            fails++; $display("FAIL next_pending got busy=%b page=%0d exp 1/1", oBUSY, oPAGE);
        end
        tests++;
        iVSYNC = 1'b0;
        @(posedge iCLK); @(posedge iCLK); @(negedge iCLK);
        if (oPAGE !== 2'd1 || oFLIP_DONE !== 1'b0) begin
            fails++; $display("FAIL next_early got page=%0d done=%b exp 1/0", oPAGE, oFLIP_DONE);
        end
        tests++;
        @(negedge iCLK);
        if (oPAGE !== 2'd2 || oRD_ADDR !== 23'h258000) begin
            fails++; $display("FAIL next_flip got page=%0d addr=%h exp 2/258000", oPAGE, oRD_ADDR);
        end
        tests++;
        if (oFLIP_DONE !== 1'b1 || oFACTOR_RSTN !== 1'b0) begin
            fails++; $display("FAIL next_pulse got done=%b frst=%b exp 1/0", oFLIP_DONE, oFACTOR_RSTN);
        end
        tests++;
        @(negedge iCLK);
        if (oFLIP_DONE !== 1'b0 || oFACTOR_RSTN !== 1'b1 || oBUSY !== 1'b1) begin
            fails++; $display("FAIL next_pulse_end got done=%b frst=%b busy=%b exp 0/1/1", oFLIP_DONE, oFACTOR_RSTN, oBUSY);
        end
        tests++;
        iVSYNC = 1'b1;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic test_hold_prev();
        pulse_req(1'b0, 1'b1);
        if (oBUSY !== 1'b1 || oPAGE !== 2'd2) begin
            fails++; $display("FAIL hold_prev_drop got busy=%b page=%0d exp 1/2", oBUSY, oPAGE);
        end
        tests++;
        frame();
        if (oBUSY !== 1'b1) begin fails++; $display("FAIL hold_one_frame got busy=%b exp 1", oBUSY); end
        tests++;
        frame();
        if (oBUSY !== 1'b0 || oPAGE !== 2'd2) begin
            fails++; $display("FAIL hold_exit got busy=%b page=%0d exp 0/2", oBUSY, oPAGE);
        end
        tests++;
        if (flip_count != 1) begin fails++; $display("FAIL hold_flips got %0d exp 1", flip_count); end
        tests++;
    endtask

    task automatic test_boundary();
        pulse_req(1'b1, 1'b0);
        if (oBUSY !== 1'b0 || oPAGE !== 2'd2) begin
            fails++; $display("FAIL bound_next got busy=%b page=%0d exp 0/2", oBUSY, oPAGE);
        end
        tests++;
        pulse_req(1'b1, 1'b1);
        if (oBUSY !== 1'b0 || oPAGE !== 2'd2) begin
            fails++; $display("FAIL bound_both got busy=%b page=%0d exp 0/2", oBUSY, oPAGE);
        end
        tests++;
        frame();
        if (oPAGE !== 2'd2 || oRD_ADDR !== 23'h258000 || flip_count != 1) begin
            fails++; $display("FAIL bound_frame got page=%0d addr=%h flips=%0d exp 2/258000/1", oPAGE, oRD_ADDR, flip_count);
        end
        tests++;
    endtask

    task automatic test_auto();
        iAUTO_PERIOD = 8'd3;
        iAUTO_EN = 1'b1;
        frame(); frame();
        if (oBUSY !== 1'b0) begin fails++; $display("FAIL auto_early got busy=%b exp 0", oBUSY); end
        tests++;
        frame();
        if (oBUSY !== 1'b1 || oPAGE !== 2'd2) begin
            fails++; $display("FAIL auto_pending got busy=%b page=%0d exp 1/2", oBUSY, oPAGE);
        end
        tests++;
        frame();
        if (oPAGE !== 2'd0 || oRD_ADDR !== 23'h000000) begin
            fails++; $display("FAIL auto_wrap got page=%0d addr=%h exp 0/000000", oPAGE, oRD_ADDR);
        end
        tests++;
        frame(); frame();
        if (oBUSY !== 1'b0) begin fails++; $display("FAIL auto_hold_exit got busy=%b exp 0", oBUSY); end
        tests++;
        frame(); frame(); frame();
        if (oPAGE !== 2'd0 || oBUSY !== 1'b1) begin
            fails++; $display("FAIL auto_second_pending got page=%0d busy=%b exp 0/1", oPAGE, oBUSY);
        end
        tests++;
        frame();
        if (oPAGE !== 2'd1 || oRD_ADDR !== 23'h12C000) begin
            fails++; $display("FAIL auto_second got page=%0d addr=%h exp 1/12c000", oPAGE, oRD_ADDR);
        end
        tests++;
        iAUTO_EN = 1'b0;
        frame(); frame(); frame(); frame(); frame();
        if (oBUSY !== 1'b0 || oPAGE !== 2'd1 || flip_count != 3) begin
            fails++; $display("FAIL auto_off got busy=%b page=%0d flips=%0d exp 0/1/3", oBUSY, oPAGE, flip_count);
        end
        tests++;
    endtask

    task automatic test_load_busy();
        iLOAD_BUSY = 1'b1;
        pulse_req(1'b0, 1'b1);
        frame(); frame();
        if (oPAGE !== 2'd1 || oBUSY !== 1'b1 || flip_count != 3) begin
            fails++; $display("FAIL load_defer got page=%0d busy=%b flips=%0d exp 1/1/3", oPAGE, oBUSY, flip_count);
        end
        tests++;
        iLOAD_BUSY = 1'b0;
        frame();
        if (oPAGE !== 2'd0 || oRD_ADDR !== 23'h000000 || flip_count != 4) begin
            fails++; $display("FAIL load_flip got page=%0d addr=%h flips=%0d exp 0/000000/4", oPAGE, oRD_ADDR, flip_count);
        end
        tests++;
        frame(); frame();
        if (oBUSY !== 1'b0) begin fails++; $display("FAIL load_hold_exit got busy=%b exp 0", oBUSY); end
        tests++;
    endtask

    task automatic test_reset_abort();
        pulse_req(1'b1, 1'b0);
        if (oBUSY !== 1'b1) begin fails++; $display("FAIL abort_pending got busy=%b exp 1", oBUSY); end
        tests++;
        #2;
        iRSTN = 1'b0;
        #1;
        if (oPAGE !== 2'd1 || oRD_ADDR !== 23'h12C000 || oBUSY !== 1'b0) begin
            fails++; $display("FAIL abort_async got page=%0d addr=%h busy=%b exp 1/12c000/0", oPAGE, oRD_ADDR, oBUSY);
        end
        tests++;
        snap = flip_count;
        repeat (2) @(negedge iCLK);
        iRSTN = 1'b1;
        repeat (4) @(negedge iCLK);
        frame(); frame();
        if (flip_count != snap || oBUSY !== 1'b0) begin
            fails++; $display("FAIL abort_no_flip got flips=%0d busy=%b exp %0d/0", flip_count, oBUSY, snap);
        end
        tests++;
        if (oPAGE !== 2'd1 || oRD_ADDR !== 23'h12C000) begin
            fails++; $display("FAIL abort_page got page=%0d addr=%h exp 1/12c000", oPAGE, oRD_ADDR);
        end
        tests++;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        flip_count = 0;
        snap = 0;
        test_reset();
        test_next();
        test_hold_prev();
        test_boundary();
        test_auto();
        test_load_busy();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
